// File: rtl/can_fifo_controller.sv
// can_fifo_controller: TX FIFO + bit-timed serial framer, RX deserialiser with held register.
// Define CAN_LOOPBACK_EN to feed the registered can_out into RX instead of can_in.
module can_fifo_controller #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                tx_data,
    input  logic                             tx_wr,
    output logic                             tx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  tx_count,
    output logic                             busy,
    output logic                             can_out,
    input  logic                             can_in,
    output logic [DATA_W-1:0]                rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ack,
    output logic                             rx_err,
    output logic                             rx_overrun
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(BIT_CYCLES);
    localparam int BW  = $clog2(DATA_W);

    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] LAST_CYC = BCW'(BIT_CYCLES - 1);
    localparam logic [BCW-1:0] MID_CYC  = BCW'(BIT_CYCLES / 2 - 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_SOF, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    assign w_empty  = (r_count == '0);
    assign tx_full  = (r_count == FULL_CNT);
    assign tx_count = r_count;
    assign w_push   = tx_wr & ~tx_full;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    tx_state_t         r_tx_state, w_tx_state_n;
    logic [BCW-1:0]    r_tx_cyc, w_tx_cyc_n;
    logic [BW-1:0]     r_tx_bit, w_tx_bit_n;
    logic [DATA_W-1:0] r_tx_sh, w_tx_sh_n;
    logic              r_tx_par, w_tx_par_n;
    logic              r_can_out, w_can_out_n;
    logic              w_tx_end;

    assign w_tx_end = (r_tx_cyc == LAST_CYC);
    assign can_out  = r_can_out;
    assign busy     = (r_tx_state != TX_IDLE) | ~w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cyc   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_can_out  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cyc   <= w_tx_cyc_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_sh    <= w_tx_sh_n;
            r_tx_par   <= w_tx_par_n;
            r_can_out  <= w_can_out_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cyc_n   = r_tx_cyc;
        w_tx_bit_n   = r_tx_bit;
        w_tx_sh_n    = r_tx_sh;
        w_tx_par_n   = r_tx_par;
        w_can_out_n  = r_can_out;
        w_pop        = 1'b0;
        if (r_tx_state != TX_IDLE) begin
            w_tx_cyc_n = w_tx_end ? '0 : r_tx_cyc + 1'b1;
        end
        unique case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_tx_sh_n    = w_head;
                    w_tx_par_n   = ^w_head;
                    w_tx_cyc_n   = '0;
                    w_tx_state_n = TX_SOF;
                    w_can_out_n  = 1'b0;
                end
            end
            TX_SOF: begin
                if (w_tx_end) begin
                    w_tx_state_n = TX_DATA;
                    w_tx_bit_n   = '0;
                    w_can_out_n  = r_tx_sh[DATA_W-1];
                    w_tx_sh_n    = r_tx_sh << 1;
                end
            end
            TX_DATA: begin
                if (w_tx_end) begin
                    if (r_tx_bit == LAST_BIT) begin
                        w_tx_state_n = TX_PARITY;
                        w_can_out_n  = r_tx_par;
                    end else begin
                        w_tx_bit_n  = r_tx_bit + 1'b1;
                        w_can_out_n = r_tx_sh[DATA_W-1];
                        w_tx_sh_n   = r_tx_sh << 1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_end) begin
                    w_tx_state_n = TX_STOP;
                    w_can_out_n  = 1'b1;
                end
            end
            TX_STOP: begin
                // Chain straight into the next SOF so frames go back-to-back
                if (w_tx_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_tx_sh_n    = w_head;
                        w_tx_par_n   = ^w_head;
                        w_tx_state_n = TX_SOF;
                        w_can_out_n  = 1'b0;
                    end else begin
                        w_tx_state_n = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    logic w_rx_in;

`ifdef CAN_LOOPBACK_EN
    assign w_rx_in = r_can_out;
`else
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= can_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_in = r_sync2;
`endif

    rx_state_t         r_rx_state, w_rx_state_n;
    logic [BCW-1:0]    r_rx_cyc, w_rx_cyc_n;
    logic [BW-1:0]     r_rx_bit, w_rx_bit_n;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh_n;
    logic              r_rx_par, w_rx_par_n;
    logic              r_rx_prev;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_n;
    logic              r_rx_valid, w_rx_valid_n;
    logic              r_rx_err, w_rx_err_n;
    logic              r_rx_ovr, w_rx_ovr_n;
    logic              w_rx_end;
    logic              w_rx_mid;
    logic              w_rx_good;

    assign w_rx_end   = (r_rx_cyc == LAST_CYC);
    assign w_rx_mid   = (r_rx_cyc == MID_CYC);
    assign w_rx_good  = w_rx_in & (r_rx_par == ^r_rx_sh);
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_err     = r_rx_err;
    assign rx_overrun = r_rx_ovr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cyc   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_par   <= 1'b0;
            r_rx_prev  <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cyc   <= w_rx_cyc_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_sh    <= w_rx_sh_n;
            r_rx_par   <= w_rx_par_n;
            r_rx_prev  <= w_rx_in;
            r_rx_data  <= w_rx_data_n;
            r_rx_valid <= w_rx_valid_n;
            r_rx_err   <= w_rx_err_n;
            r_rx_ovr   <= w_rx_ovr_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cyc_n   = r_rx_cyc;
        w_rx_bit_n   = r_rx_bit;
        w_rx_sh_n    = r_rx_sh;
        w_rx_par_n   = r_rx_par;
        w_rx_data_n  = r_rx_data;
        w_rx_valid_n = r_rx_valid & ~rx_ack;
        w_rx_err_n   = 1'b0;
        w_rx_ovr_n   = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev & ~w_rx_in) begin
                    w_rx_state_n = RX_START;
                    w_rx_cyc_n   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real SOF, high means a glitch
                w_rx_cyc_n = w_rx_mid ? '0 : r_rx_cyc + 1'b1;
                if (w_rx_mid) begin
                    w_rx_state_n = w_rx_in ? RX_IDLE : RX_DATA;
                    w_rx_bit_n   = '0;
                end
            end
            RX_DATA: begin
                w_rx_cyc_n = w_rx_end ? '0 : r_rx_cyc + 1'b1;
                if (w_rx_end) begin
                    w_rx_sh_n = {r_rx_sh[DATA_W-2:0], w_rx_in};
                    if (r_rx_bit == LAST_BIT) begin
                        w_rx_state_n = RX_PARITY;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                w_rx_cyc_n = w_rx_end ? '0 : r_rx_cyc + 1'b1;
                if (w_rx_end) begin
                    w_rx_par_n   = w_rx_in;
                    w_rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                w_rx_cyc_n = w_rx_end ? '0 : r_rx_cyc + 1'b1;
                if (w_rx_end) begin
                    w_rx_state_n = RX_IDLE;
                    if (!w_rx_good) begin
                        w_rx_err_n = 1'b1;
                    end else if (!r_rx_valid || rx_ack) begin
                        w_rx_data_n  = r_rx_sh;
                        w_rx_valid_n = 1'b1;
                    end else begin
                        w_rx_ovr_n = 1'b1;
                    end
                end
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_can_fifo_controller.sv
// tb_can_fifo_controller: scoreboard bench for can_fifo_controller.
// TX frames decoded off can_out, RX events checked against queued expectations.
module tb_can_fifo_controller;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic [2:0] tx_count;
    logic       busy;
    logic       can_out;
    logic       can_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_err;
    logic       rx_overrun;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } rx_ev_t;

    localparam int EV_VALID = 0;
    localparam int EV_ERR   = 1;
    localparam int EV_OVR   = 2;

    logic [7:0] tx_exp [$];
    rx_ev_t     rx_exp [$];
    int         n_chk;
    int         n_err;
    bit         rx_mon_en;

    can_fifo_controller #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .BIT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_full    (tx_full),
        .tx_count   (tx_count),
        .busy       (busy),
        .can_out    (can_out),
        .can_in     (can_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_err     (rx_err),
        .rx_overrun (rx_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_can_out", can_out, 1);
        chk("rst_full", tx_full, 0);
        chk("rst_count", tx_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_rx_ovr", rx_overrun, 0);
    endtask

    task automatic wait_idle(input int max);
        int c = 0;
        while ((busy || tx_exp.size() != 0) && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("tx_drain", tx_exp.size(), 0);
        chk("tx_busy_end", busy, 0);
    endtask

    task automatic wait_rx(input int max);
        int c = 0;
        while (rx_exp.size() != 0 && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("rx_drain", rx_exp.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip,
                              input logic stopv);
        logic [10:0] bits;
        bits = {1'b0, d, (^d) ^ pflip, stopv};
        for (int i = 10; i >= 0; i--) begin
            can_in = bits[i];
            repeat (4) @(negedge clk);
        end
        can_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Bus monitor: sample each bit mid-way, abort on reset
    initial begin : tx_mon
        logic [10:0] f;
        logic [7:0]  e;
        bit          ok;
        forever begin
            @(negedge clk);
            if (!reset && !can_out) begin
                f  = '0;
                ok = 1'b1;
                for (int i = 1; i <= 42; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        ok = 1'b0;
                        break;
                    end
                    if (i % 4 == 2) f = {f[9:0], can_out};
                end
                if (ok) begin
                    chk("tx_pend", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) begin
                        e = tx_exp.pop_front();
                        chk("tx_sof", f[10], 0);
                        chk("tx_data", f[9:2], e);
                        chk("tx_par", f[1], ^e);
                        chk("tx_stop", f[0], 1);
                    end
                end
            end
        end
    end

    initial begin : rx_mon
        bit     rv_q;
        int     k;
        rx_ev_t e;
        rv_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_mon_en) begin
                k = -1;
                if (rx_err) k = EV_ERR;
                else if (rx_overrun) k = EV_OVR;
                else if (rx_valid && !rv_q) k = EV_VALID;
                if (k >= 0) begin
                    chk("rx_pend", rx_exp.size() != 0, 1);
                    if (rx_exp.size() != 0) begin
                        e = rx_exp.pop_front();
                        chk("rx_kind", k, e.kind);
                        if (k != EV_ERR) chk("rx_ev_data", rx_data, e.data);
                    end
                end
            end
            rv_q = rx_valid;
        end
    end

    initial begin
        int cyc;
        int cnt_exp [6];
        cnt_exp = '{0, 1, 1, 2, 3, 4};
        n_chk     = 0;
        n_err     = 0;
        reset     = 1'b1;
        tx_wr     = 1'b0;
        tx_data   = '0;
        can_in    = 1'b1;
        rx_ack    = 1'b0;
        rx_mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        reset = 1'b0;
`ifndef CAN_LOOPBACK_EN
        rx_mon_en = 1'b1;
`endif

        // reset in the middle of a SOF
        @(negedge clk);
        tx_data = 8'h77;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_low", can_out, 0);
        #2 reset = 1'b1;
        #1 chk("rst_async", can_out, 1);
        repeat (2) @(negedge clk);
        chk_reset();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("quiet_can", can_out, 1);
        chk("quiet_busy", busy, 0);

        // single frame latency
        tx_data = 8'hA5;
        tx_wr   = 1'b1;
        tx_exp.push_back(8'hA5);
        @(negedge clk);
        tx_wr = 1'b0;
        chk("lat_n1", can_out, 1);
        @(negedge clk);
        chk("lat_n2", can_out, 0);
        cyc = 2;
        while (busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_lat", cyc, 46);
        wait_idle(10);

        // six pushes into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            chk("fill_count", tx_count, cnt_exp[i]);
            chk("fill_full", tx_full, i == 5);
            tx_data = 8'(i + 1);
            tx_wr   = 1'b1;
            if (i < 5) tx_exp.push_back(8'(i + 1));
            @(negedge clk);
        end
        tx_wr = 1'b0;
        wait_idle(400);

`ifndef CAN_LOOPBACK_EN
        rx_exp.push_back('{kind: EV_VALID, data: 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_rx(20);
        chk("rx_data", rx_data, 8'h3C);
        repeat (10) @(negedge clk);
        chk("rx_hold", rx_valid, 1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk("rx_ack_clr", rx_valid, 0);

        rx_exp.push_back('{kind: EV_ERR, data: 8'h00});
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_rx(20);
        chk("par_valid", rx_valid, 0);

        rx_exp.push_back('{kind: EV_ERR, data: 8'h00});
        send_frame(8'h55, 1'b0, 1'b0);
        wait_rx(20);
        chk("stop_valid", rx_valid, 0);

        can_in = 1'b0;
        @(negedge clk);
        can_in = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_valid", rx_valid, 0);

        rx_exp.push_back('{kind: EV_VALID, data: 8'h11});
        send_frame(8'h11, 1'b0, 1'b1);
        rx_exp.push_back('{kind: EV_OVR, data: 8'h11});
        send_frame(8'h22, 1'b0, 1'b1);
        wait_rx(20);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk("ovr_ack_clr", rx_valid, 0);
`else
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        rx_mon_en = 1'b1;
        can_in    = 1'b0;
        rx_exp.push_back('{kind: EV_VALID, data: 8'h5A});
        tx_exp.push_back(8'h5A);
        tx_data = 8'h5A;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        wait_rx(100);
        wait_idle(20);
        chk("lb_data", rx_data, 8'h5A);
        chk("lb_valid", rx_valid, 1);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
